// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key event path.
// Scan bytes follow keyboard scan code set 2.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BREAK = 8'hF0;

  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;

  localparam int EVT_REL = 9;
  localparam int EVT_EXT = 8;
  localparam int EVT_W   = 10;

  typedef enum logic [1:0] {
    IDLE,
    GOT_E0,
    GOT_F0,
    GOT_E0F0
  } dec_state_t;

  function automatic logic is_ack(input logic [7:0] b);
    return (b == PS2_ACK) || (b == PS2_BAT_OK) ||
           (b == PS2_ECHO) || (b == PS2_RESEND);
  endfunction

endpackage

// File: rtl/ps2_scan_decoder.sv
// Set-2 prefix decoder producing one-cycle key event strobes.
// PS2_REPEAT_FILTER_EN adds a held-key map that drops typematic repeats.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter bit KEEP_BREAK = 1'b1,
  parameter bit FILTER_ACK = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             key_strobe,
  input  logic [7:0]       key_data,
  output logic             emit,
  output logic [EVT_W-1:0] event_word
);

  dec_state_t state_q, state_d;
  logic emit_raw;
  logic rel;
  logic ext;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    emit_raw = 1'b0;
    rel      = 1'b0;
    ext      = 1'b0;
    if (key_strobe) begin
      unique case (state_q)
        IDLE: begin
          if (key_data == PS2_EXT)        state_d = GOT_E0;
          else if (key_data == PS2_BREAK) state_d = GOT_F0;
          else if (!(FILTER_ACK && is_ack(key_data))) emit_raw = 1'b1;
        end
        GOT_E0: begin
          if (key_data == PS2_BREAK)    state_d = GOT_E0F0;
          else if (key_data != PS2_EXT) begin
            emit_raw = 1'b1;
            ext      = 1'b1;
            state_d  = IDLE;
          end
        end
        GOT_F0: begin
          if (key_data == PS2_EXT)        state_d = GOT_E0;
          else if (key_data != PS2_BREAK) begin
            emit_raw = 1'b1;
            rel      = 1'b1;
            state_d  = IDLE;
          end
        end
        GOT_E0F0: begin
          if (key_data == PS2_EXT)        state_d = GOT_E0;
          else if (key_data != PS2_BREAK) begin
            emit_raw = 1'b1;
            rel      = 1'b1;
            ext      = 1'b1;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign event_word = {rel, ext, key_data};

`ifdef PS2_REPEAT_FILTER_EN
  logic [511:0] held_q;
  logic [8:0]   held_idx;

  assign held_idx = {ext, key_data};

  // Map tracks every decoded event, even ones the FIFO later drops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         held_q <= '0;
    else if (emit_raw) held_q[held_idx] <= !rel;
  end

  assign emit = emit_raw && (rel ? KEEP_BREAK : !held_q[held_idx]);
`else
  assign emit = emit_raw && (KEEP_BREAK || !rel);
`endif

endmodule

// File: rtl/ps2_key_event_fifo.sv
// PS/2 key event decoder feeding a show-ahead FIFO for the processor.
// Optional typematic repeat filter: define PS2_REPEAT_FILTER_EN.
module ps2_key_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter bit KEEP_BREAK = 1'b1,
  parameter bit FILTER_ACK = 1'b1,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W  = ADDR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ps2_key_pressed,
  input  logic [7:0]       ps2_key_data,
  input  logic             pop,
  output logic             event_valid,
  output logic [EVT_W-1:0] event_data,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  input  logic             clear_overflow
);

  logic             emit;
  logic [EVT_W-1:0] evt;

  ps2_scan_decoder #(
    .KEEP_BREAK(KEEP_BREAK),
    .FILTER_ACK(FILTER_ACK)
  ) u_dec (
    .clock     (clock),
    .reset     (reset),
    .key_strobe(ps2_key_pressed),
    .key_data  (ps2_key_data),
    .emit      (emit),
    .event_word(evt)
  );

  logic [EVT_W-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              ovf_q;

  logic full;
  logic do_pop;
  logic do_push;
  logic drop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && (count_q != '0);
  assign do_push = emit && (!full || do_pop);
  assign drop    = emit && full && !do_pop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= evt;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)                ovf_q <= 1'b1;
      else if (clear_overflow) ovf_q <= 1'b0;
    end
  end

  assign event_valid = (count_q != '0);
  assign event_data  = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign overflow    = ovf_q;

endmodule
